cache_mem_responder: RTL and testbench
======================================

# cache_mem_responder

Behavioural-synthesisable main-memory responder for the cache controller's memory port. It accepts one 128-bit line request at a time from the controller (`mem_req_*`), services it after a fixed, parameterised latency against an internal line array, and returns a one-cycle `mem_resp_ready` pulse with read data. It sits below the cache controller in the `cache/dv` bench and in FPGA bring-up builds as the backing store.

## Interface
- `LATENCY`, 4: cycles from request capture to response pulse; legal range 1..255.
- `DEPTH_LINES`, 1024: number of 128-bit lines in the array; power of two, at least 2.
- `ADDR_LSB`, 4: byte-offset bits dropped from `mem_req_addr` (16-byte line).

- `clk` in 1: the block's single clock.
- `reset` in 1: asynchronous, active-high reset.
- `mem_req_addr` in 32: byte address of the line.
- `mem_req_data` in 128: write line data.
- `mem_req_rw` in 1: 1 = write, 0 = read.
- `mem_req_valid` in 1: request valid; the initiator holds it and all request fields stable until it sees `mem_resp_ready`.
- `mem_resp_data` out 128: read line data.
- `mem_resp_ready` out 1: one-cycle completion pulse for both reads and writes.
- `mem_rd_count` out 32: completed reads (only with `CACHE_MEM_STATS_EN`).
- `mem_wr_count` out 32: completed writes (only with `CACHE_MEM_STATS_EN`).

## Operation
- Line index = `mem_req_addr[ADDR_LSB +: $clog2(DEPTH_LINES)]`.
  - Upper address bits are ignored, so addresses alias modulo the array size.
  - Offset bits are ignored.
- FSM states:
  - IDLE: `mem_req_valid`=1 captures addr index, rw and data into request registers, loads the latency counter with `LATENCY-1`, and moves to WAIT. With `LATENCY`=1, WAIT is skipped and the FSM goes straight to RESP.
  - WAIT: decrements the counter each cycle; at counter 0 moves to RESP. `mem_req_*` inputs are ignored in this state; only captured values are used.
  - RESP: drives `mem_resp_ready`=1 for exactly this cycle.
    - Write: the captured data is written to the captured index on the exiting clock edge.
    - Read: `mem_resp_data` already holds the array line, loaded on the edge entering RESP.
    - The FSM returns to IDLE unconditionally. `mem_req_valid` seen during RESP belongs to the completed request and is not captured.
- `mem_resp_data`:
  - Changes only on the edge entering a read RESP.
  - Holds its value through later writes and idle cycles.
- Array:
  - Not cleared by `reset`; contents persist across reset.
  - Lines never written read as X in simulation.
- Back-to-back requests: the earliest next capture is the IDLE cycle immediately after RESP. This covers the controller's write-back followed by allocate, where `mem_req_valid` never drops.
- Read-after-write to the same line returns the written data, because the write commits before the next capture.

## Timing
- Capture in cycle T (IDLE, valid=1), then `mem_resp_ready`=1 in cycle T+`LATENCY`, high for 1 cycle.
- Request-to-request throughput: `LATENCY`+1 cycles per request.
- Reset values:
  - `mem_resp_ready`=0 and `mem_resp_data`=0.
  - FSM=IDLE and counter=0.
  - Stats counters=0.
- Reset asserted mid-operation (WAIT or RESP):
  - Aborts the request; no response pulse is issued.
  - A pending write is discarded, and the array is not modified.
  - The initiator must re-issue the request after reset.
- Stats counters wrap modulo 2^32.

## Configuration
- `CACHE_MEM_STATS_EN` defined:
  - `mem_rd_count` and `mem_wr_count` ports exist.
  - Each counter increments on the clock edge leaving a RESP of the matching type.
- Not defined:
  - The ports and counters are absent.
  - All other behaviour is identical.

## Test plan
- `LATENCY`=4. Write addr 0x0000_0040, data 0x0123…CDEF, then read the same address -> ready pulses exactly 4 cycles after each capture; read returns 0x0123…CDEF.
- Controller-style write-back then allocate with valid held high across both: write 0x100 then read 0x200 -> two distinct ready pulses 5 cycles apart; no extra capture during RESP.
- Aliasing with `DEPTH_LINES`=1024: write 0x0000_4010, then read 0x0000_0010 -> read returns the written line.
- Reset asserted 2 cycles into a write to 0x80 -> no ready pulse; `mem_resp_data`=0. A later read of 0x80 returns the pre-reset contents.
- `LATENCY`=1 -> ready is asserted the cycle after capture. `mem_resp_data` is unchanged after a write response.
- With `CACHE_MEM_STATS_EN` defined: 3 reads and 2 writes -> `mem_rd_count`=3, `mem_wr_count`=2. Reset -> both counters 0.

Source files
------------

// File: rtl/cache_mem_responder.sv
// +--------------------------------------------------------------------------+
// | Module      : cache_mem_responder                                        |
// | Description : Fixed-latency main-memory model for the cache controller's |
// |               memory port. One 128-bit line request at a time; a single  |
// |               cycle mem_resp_ready pulse completes reads and writes.     |
// | Options     : define CACHE_MEM_STATS_EN to add read/write completion     |
// |               counters (mem_rd_count / mem_wr_count).                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module cache_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 1024,
    parameter int ADDR_LSB    = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  mem_req_addr,
    input  logic [127:0] mem_req_data,
    input  logic         mem_req_rw,
    input  logic         mem_req_valid,
    output logic [127:0] mem_resp_data,
    output logic         mem_resp_ready
`ifdef CACHE_MEM_STATS_EN
    ,
    output logic [31:0]  mem_rd_count,
    output logic [31:0]  mem_wr_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    // Counter preload; WAIT lasts LATENCY-1 cycles so the pulse lands at T+LATENCY.
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rw_q, rw_d;
    logic [127:0]       data_q, data_d;
    logic [127:0]       resp_data_q, resp_data_d;
    logic [127:0]       mem_q [DEPTH_LINES];

    logic [IDX_W-1:0]   req_idx;
    logic               unused_addr;

    // Offset and upper address bits are dropped, so addresses alias by array size.
    assign req_idx     = mem_req_addr[ADDR_LSB +: IDX_W];
    assign unused_addr = ^mem_req_addr;

    assign mem_resp_data  = resp_data_q;
    assign mem_resp_ready = (state_q == S_RESP);

    // Next-state logic: capture in IDLE, count down in WAIT, pulse for one RESP cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        rw_d        = rw_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req_valid) begin
                    idx_d  = req_idx;
                    rw_d   = mem_req_rw;
                    data_d = mem_req_data;
                    cnt_d  = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        // Read data must be in place on the edge that enters RESP.
                        if (!mem_req_rw) begin
                            resp_data_d = mem_q[req_idx];
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Leave when the decremented count reaches zero.
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = S_RESP;
                    if (!rw_q) begin
                        resp_data_d = mem_q[idx_q];
                    end
                end
            end
            S_RESP: begin
                // Valid still high here belongs to the completed request.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and request registers; reset aborts any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            idx_q       <= '0;
            rw_q        <= 1'b0;
            data_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rw_q        <= rw_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Line array commits a write on the edge leaving RESP; never cleared by reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_RESP) && rw_q && !reset) begin
            mem_q[idx_q] <= data_q;
        end
    end

`ifdef CACHE_MEM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    assign mem_rd_count = rd_cnt_q;
    assign mem_wr_count = wr_cnt_q;

    // Completion counters step on the edge leaving RESP and wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (state_q == S_RESP) begin
            if (rw_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_cache_mem_responder                                     |
// | Description : Scoreboard bench for cache_mem_responder (LATENCY=4 main   |
// |               instance plus a LATENCY=1 instance for the short path).    |
// | Options     : CACHE_MEM_STATS_EN adds completion counter checks.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cache_mem_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    typedef struct {
        bit           rw;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic         rw;
    logic         valid;
    logic [127:0] rdata;
    logic         ready;

    logic [31:0]  addr1;
    logic [127:0] wdata1;
    logic         rw1;
    logic         valid1;
    logic [127:0] rdata1;
    logic         ready1;

`ifdef CACHE_MEM_STATS_EN
    logic [31:0]  rd_count, wr_count, rd_count1, wr_count1;
`endif

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    exp_t         sb_q[$];
    logic [127:0] model [int];
    logic [127:0] hold;
    bit           after_resp = 0;
    int           rd_done = 0;
    int           wr_done = 0;

    cache_mem_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH), .ADDR_LSB(4)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req_addr   (addr),
        .mem_req_data   (wdata),
        .mem_req_rw     (rw),
        .mem_req_valid  (valid),
        .mem_resp_data  (rdata),
        .mem_resp_ready (ready)
`ifdef CACHE_MEM_STATS_EN
        ,
        .mem_rd_count   (rd_count),
        .mem_wr_count   (wr_count)
`endif
    );

    cache_mem_responder #(.LATENCY(1), .DEPTH_LINES(DEPTH), .ADDR_LSB(4)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .mem_req_addr   (addr1),
        .mem_req_data   (wdata1),
        .mem_req_rw     (rw1),
        .mem_req_valid  (valid1),
        .mem_resp_data  (rdata1),
        .mem_resp_ready (ready1)
`ifdef CACHE_MEM_STATS_EN
        ,
        .mem_rd_count   (rd_count1),
        .mem_wr_count   (wr_count1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every ready pulse; tracks the held read data.
    initial begin
        hold = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold    = '0;
                rd_done = 0;
                wr_done = 0;
            end
            if (ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready actual=1 required=0 (t=%0t)", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("ready_cycle", 128'(cyc), 128'(e.cyc));
                    if (!e.rw) begin
                        hold = e.data;
                        rd_done++;
                    end else begin
                        wr_done++;
                    end
                end
            end
            chk("resp_data", rdata, hold);
        end
    end

    // Issue one request to the main instance and wait for its ready pulse.
    task automatic issue(input logic [31:0] a, input logic [127:0] d, input bit w);
        exp_t e;
        int   line;
        bit   got;
        line  = int'((a >> 4) % DEPTH);
        e.rw  = w;
        e.cyc = cyc + LAT + (after_resp ? 1 : 0);
        if (w) begin
            model[line] = d;
            e.data      = '0;
        end else begin
            e.data = model[line];
        end
        sb_q.push_back(e);
        addr  = a;
        wdata = d;
        rw    = w;
        valid = 1'b1;
        got   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual=0 required=1 (addr=%h)", a);
            sb_q.delete();
            valid = 1'b0;
        end
        after_resp = got;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
        if (n > 0) after_resp = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        addr   = '0; wdata  = '0; rw  = 1'b0; valid  = 1'b0;
        addr1  = '0; wdata1 = '0; rw1 = 1'b0; valid1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ready", ready, 1'b0);
        chk("reset_data", rdata, '0);
`ifdef CACHE_MEM_STATS_EN
        chk("reset_rd_count", rd_count, '0);
        chk("reset_wr_count", wr_count, '0);
`endif
        #1 reset = 1'b0;
        @(negedge clk);

        // LATENCY=1 instance: ready the cycle after capture, data held across writes.
        addr1 = 32'h30; wdata1 = 128'hAAAA_5555_0000_1111_2222_3333_4444_5555;
        rw1 = 1'b1; valid1 = 1'b1;
        @(negedge clk);
        chk("l1_wr_ready", ready1, 1'b1);
        chk("l1_wr_data", rdata1, '0);
        valid1 = 1'b0;
        @(negedge clk);
        chk("l1_idle_ready", ready1, 1'b0);
        rw1 = 1'b0; valid1 = 1'b1;
        @(negedge clk);
        chk("l1_rd_ready", ready1, 1'b1);
        chk("l1_rd_data", rdata1, 128'hAAAA_5555_0000_1111_2222_3333_4444_5555);
        valid1 = 1'b0;
        @(negedge clk);
        rw1 = 1'b1; wdata1 = 128'h1234; valid1 = 1'b1;
        @(negedge clk);
        chk("l1_wr2_ready", ready1, 1'b1);
        chk("l1_wr2_hold", rdata1, 128'hAAAA_5555_0000_1111_2222_3333_4444_5555);
        valid1 = 1'b0;
        @(negedge clk);
        rw1 = 1'b0; valid1 = 1'b1;
        @(negedge clk);
        chk("l1_rd2_data", rdata1, 128'h1234);
        valid1 = 1'b0;

        // Main instance directed cases.
        idle(2);
        issue(32'h0000_0040, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b1);
        idle(2);
        issue(32'h0000_0040, '0, 1'b0);
        idle(2);
        issue(32'h0000_0200, 128'h2222_0000_2222_0000_2222_0000_2222_0000, 1'b1);
        idle(1);
        // Write-back then allocate with valid held high across both requests.
        issue(32'h0000_0100, 128'h1111_BEEF_1111_BEEF_1111_BEEF_1111_BEEF, 1'b1);
        issue(32'h0000_0200, '0, 1'b0);
        idle(2);
        // Aliasing: 0x4010 and 0x10 share line 1.
        issue(32'h0000_4010, 128'hA11A_5ED0_A11A_5ED0_A11A_5ED0_A11A_5ED0, 1'b1);
        idle(1);
        issue(32'h0000_0010, '0, 1'b0);
        idle(1);
        issue(32'h0000_0080, 128'h8080_8080_0000_0000_8080_8080_0000_0001, 1'b1);
        idle(1);

        // Reset two cycles into a write to 0x80: aborted, array untouched.
        addr = 32'h80; wdata = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD; rw = 1'b1; valid = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("abort_ready", ready, 1'b0);
        chk("abort_data", rdata, '0);
`ifdef CACHE_MEM_STATS_EN
        chk("abort_rd_count", rd_count, '0);
        chk("abort_wr_count", wr_count, '0);
`endif
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        after_resp = 1'b0;
        idle(2);
        issue(32'h0000_0080, '0, 1'b0);

        // Randomized traffic over a small line pool with random upper/offset bits.
        for (int n = 0; n < 40; n++) begin
            int           line;
            logic [31:0]  a;
            bit           w;
            line = $urandom_range(0, 31);
            a    = ($urandom & 32'hFFFF_C000) | (32'(line) << 4) | 32'($urandom_range(0, 15));
            w    = !model.exists(line) || ($urandom_range(0, 1) == 1);
            idle($urandom_range(0, 2));
            issue(a, {$urandom, $urandom, $urandom, $urandom}, w);
        end

        idle(3);
        chk("scoreboard_empty", 128'(sb_q.size()), '0);
`ifdef CACHE_MEM_STATS_EN
        chk("final_rd_count", rd_count, 128'(rd_done));
        chk("final_wr_count", wr_count, 128'(wr_done));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
